// File: rtl/led_pkg.sv
// Shared definitions for the board "alive" LED: pattern encodings,
// the heartbeat flash mask and the LED drive selection.
package led_pkg;

   // Pattern select as presented on the mode pins.
   typedef enum logic [1:0] {
      MODE_OFF       = 2'b00,
      MODE_ON        = 2'b01,
      MODE_BLINK     = 2'b10,
      MODE_HEARTBEAT = 2'b11
   } led_mode_e;

   // One bit per half-period phase. A set bit lights the LED for that
   // whole half-period, giving two short flashes per eight half-periods.
   localparam logic [7:0] HB_MASK = 8'b0000_0101;

   // LED value for the coming cycle. It takes the blink and phase values
   // that the same clock edge is about to store, so the LED never lags the
   // pattern state by a cycle.
   function automatic logic led_drive(input led_mode_e  m,
                                      input logic       blink_nxt,
                                      input logic [2:0] phase_nxt);
      logic lit;
      lit = 1'b0;
      case (m)
         MODE_OFF:       lit = 1'b0;
         MODE_ON:        lit = 1'b1;
         MODE_BLINK:     lit = blink_nxt;
         MODE_HEARTBEAT: lit = HB_MASK[phase_nxt];
         default:        lit = 1'b0;
      endcase
      return lit;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running half-period prescaler for the LED pattern engine.
// Produces a registered one-cycle tick at every half-period boundary and a
// same-cycle wrap indication so the owner can update state on that edge.
module led_tick_gen #(
   parameter int CLK_FREQ_HZ = 128_000_000,
   parameter int BLINK_HZ    = 1
) (
   input  logic clk_128M,
   input  logic rst_n,
   output logic tick_o,
   output logic wrap_o
);

   localparam int HALF  = CLK_FREQ_HZ / (2 * BLINK_HZ);
   localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

   // A fractional or sub-two-cycle half-period cannot be represented.
   if ((HALF < 2) || ((HALF * 2 * BLINK_HZ) != CLK_FREQ_HZ)) begin : g_bad_params
      $error("led_tick_gen: CLK_FREQ_HZ/(2*BLINK_HZ) must be an exact integer >= 2");
   end

   logic [CNT_W-1:0] cnt;

   // High while the counter sits on its last count; the next edge wraps it.
   assign wrap_o = (cnt == LAST);

   // Count 0..HALF-1 regardless of pattern; strobe tick on the wrap edge.
   always_ff @(posedge clk_128M) begin
      if (!rst_n) begin
         cnt    <= '0;
         tick_o <= 1'b0;
      end else if (wrap_o) begin
         cnt    <= '0;
         tick_o <= 1'b1;
      end else begin
         cnt    <= cnt + 1'b1;
         tick_o <= 1'b0;
      end
   end

endmodule

// File: rtl/led_heartbeat.sv
// Board-level "alive" indicator for led[7]. Divides the fabric clock into
// half-period ticks and turns them into off / on / blink / heartbeat
// patterns on one registered LED output.
module led_heartbeat
   import led_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 128_000_000,
   parameter int BLINK_HZ    = 1
) (
   input  logic       clk_128M,
   input  logic       rst_n,
   input  logic [1:0] mode,
   output logic       led,
   output logic       tick
);

   logic       wrap;
   logic       blink;
   logic [2:0] phase;
   logic       blink_nxt;
   logic [2:0] phase_nxt;

   led_tick_gen #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .BLINK_HZ    (BLINK_HZ)
   ) u_tick_gen (
      .clk_128M (clk_128M),
      .rst_n    (rst_n),
      .tick_o   (tick),
      .wrap_o   (wrap)
   );

   // Pattern state advances on the same edge the prescaler wraps, so the
   // blink toggle and the tick rise together. Mode never disturbs it.
   assign blink_nxt = wrap ? ~blink : blink;
   assign phase_nxt = wrap ? (phase + 3'd1) : phase;

   // Hold the pattern state and register the selected LED drive.
   always_ff @(posedge clk_128M) begin
      if (!rst_n) begin
         blink <= 1'b0;
         phase <= 3'd0;
         led   <= 1'b0;
      end else begin
         blink <= blink_nxt;
         phase <= phase_nxt;
         led   <= led_drive(led_mode_e'(mode), blink_nxt, phase_nxt);
      end
   end

endmodule

// File: tb/tb_led_heartbeat.sv
// Directed bench for led_heartbeat with HALF = 8 (16 Hz clock, 1 Hz blink).
module tb_led_heartbeat;
   import led_pkg::*;

   localparam int HALF = 8;

   logic       clk_128M;
   logic       rst_n;
   logic [1:0] mode;
   logic       led;
   logic       tick;

   int checks;
   int errors;

   // Reference state, advanced before each edge from the driven inputs.
   int   m_cnt;
   int   m_phase;
   logic m_blink;
   logic m_led;
   logic m_tick;
   logic [1:0] sb[$];

   led_heartbeat #(
      .CLK_FREQ_HZ (16),
      .BLINK_HZ    (1)
   ) dut (
      .clk_128M (clk_128M),
      .rst_n    (rst_n),
      .mode     (mode),
      .led      (led),
      .tick     (tick)
   );

   initial clk_128M = 1'b0;
   always #5 clk_128M = ~clk_128M;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Predict the outputs of the coming edge, queue them, clock, then compare.
   task automatic cyc(input string tag);
      logic [1:0] exp;
      if (!rst_n) begin
         m_cnt = 0; m_phase = 0; m_blink = 1'b0; m_tick = 1'b0; m_led = 1'b0;
      end else begin
         if (m_cnt == HALF - 1) begin
            m_cnt   = 0;
            m_tick  = 1'b1;
            m_blink = !m_blink;
            m_phase = (m_phase + 1) % 8;
         end else begin
            m_cnt  = m_cnt + 1;
            m_tick = 1'b0;
         end
         case (mode)
            2'b00:   m_led = 1'b0;
            2'b01:   m_led = 1'b1;
            2'b10:   m_led = m_blink;
            default: m_led = (m_phase == 0) || (m_phase == 2);
         endcase
      end
      sb.push_back({m_led, m_tick});
      @(posedge clk_128M);
      #1;
      exp = sb.pop_front();
      chk(tag, {30'd0, led, tick}, {30'd0, exp});
   endtask

   initial begin
      int k;
      int n;
      int last_rise;
      int bad_gap;
      int rises;
      logic prev_led;
      logic hb_pat[1:64];
      int hb_diff;

      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      mode   = MODE_BLINK;

      // 1. Reset and count
      for (int i = 0; i < 3; i++) begin
         cyc("rst_hold");
         chk("rst_led", {31'd0, led}, 32'd0);
         chk("rst_tick", {31'd0, tick}, 32'd0);
      end
      rst_n = 1'b1;
      for (k = 1; k <= 26; k++) begin
         cyc("t1_sb");
         if (k == 7)  chk("t1_led_c7", {31'd0, led}, 32'd0);
         if (k == 8)  chk("t1_tick_c8", {31'd0, tick}, 32'd1);
         if (k == 8)  chk("t1_led_c8", {31'd0, led}, 32'd1);
         if (k == 9)  chk("t1_tick_c9", {31'd0, tick}, 32'd0);
         if (k == 15) chk("t1_led_c15", {31'd0, led}, 32'd1);
         if (k == 16) chk("t1_tick_c16", {31'd0, tick}, 32'd1);
         if (k == 16) chk("t1_led_c16", {31'd0, led}, 32'd0);
         if (k == 24) chk("t1_tick_c24", {31'd0, tick}, 32'd1);
      end

      // 2. Static modes
      mode = MODE_OFF;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         cyc("t2_off_sb");
         if (led !== 1'b0) n++;
      end
      chk("t2_off_lit_cycles", n, 0);
      mode = MODE_ON;
      cyc("t2_on_sb");
      chk("t2_on_after_1", {31'd0, led}, 32'd1);
      for (int i = 0; i < 20; i++) cyc("t2_on_sb");

      // 3. Heartbeat from reset
      rst_n = 1'b0;
      mode  = MODE_HEARTBEAT;
      cyc("t3_rst");
      rst_n = 1'b1;
      for (k = 1; k <= 128; k++) begin
         cyc("t3_sb");
         if (k <= 64) hb_pat[k] = led;
      end
      chk("t3_led_c4", {31'd0, hb_pat[4]}, 32'd1);
      chk("t3_led_c12", {31'd0, hb_pat[12]}, 32'd0);
      chk("t3_led_c20", {31'd0, hb_pat[20]}, 32'd1);
      chk("t3_led_c28", {31'd0, hb_pat[28]}, 32'd0);
      chk("t3_led_c64", {31'd0, hb_pat[64]}, 32'd1);
      // Second 64-cycle window replayed against the first.
      hb_diff = 0;
      for (k = 65; k <= 128; k++) begin
         cyc("t3_rep_sb");
         if (led !== hb_pat[k - 64]) hb_diff++;
      end
      chk("t3_repeat_64", hb_diff, 0);

      // 4. Mid-run reset at cnt=5
      mode  = MODE_BLINK;
      rst_n = 1'b0;
      cyc("t4_rst");
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) cyc("t4_pre");
      rst_n = 1'b0;
      cyc("t4_midrst");
      chk("t4_led_in_rst", {31'd0, led}, 32'd0);
      chk("t4_tick_in_rst", {31'd0, tick}, 32'd0);
      rst_n = 1'b1;
      n = 0;
      for (k = 1; k <= 20 && n == 0; k++) begin
         cyc("t4_sb");
         if (tick === 1'b1) n = k;
      end
      chk("t4_first_tick_gap", n, 8);

      // 5. Mode hop BLINK -> OFF -> BLINK across a tick boundary
      for (int i = 0; i < 10; i++) cyc("t5_blink_a");
      mode = MODE_OFF;
      for (int i = 0; i < 9; i++) cyc("t5_off");
      mode = MODE_BLINK;
      cyc("t5_return");
      chk("t5_return_led", {31'd0, led}, {31'd0, m_blink});
      for (int i = 0; i < 20; i++) cyc("t5_blink_b");

      // 6. Long run in BLINK
      rst_n = 1'b0;
      cyc("t6_rst");
      rst_n     = 1'b1;
      n         = 0;
      rises     = 0;
      bad_gap   = 0;
      last_rise = -1;
      prev_led  = led;
      for (k = 1; k <= 10_000; k++) begin
         cyc("t6_sb");
         if (tick === 1'b1) n++;
         if (led === 1'b1 && prev_led === 1'b0) begin
            rises++;
            if (last_rise >= 0 && (k - last_rise) != 16) bad_gap++;
            last_rise = k;
         end
         prev_led = led;
      end
      chk("t6_tick_count", n, 1250);
      chk("t6_led_rises", rises, 625);
      chk("t6_led_period", bad_gap, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
